// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared port codes and state encoding for the mio peripheral
package mio_pkg;

  localparam logic MIO_PORT_GPIO = 1'b0;
  localparam logic MIO_PORT_UART = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    GPIO_DONE,
    START,
    DATA,
    STOP,
    UART_DONE
  } mio_state_e;

endpackage

// File: rtl/mio_uart_tx.sv
// rtl/mio_uart_tx.sv - 8N1 LSB-first serialiser with a one-cycle fin pulse after the stop bit
module mio_uart_tx
  import mio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       fin
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  mio_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          txd_q, txd_d;
  logic          fin_q, fin_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    txd_d   = txd_q;
    fin_d   = 1'b0;
    case (state_q)
      // UART_DONE behaves like IDLE so a request in the done cycle starts a new frame
      IDLE, UART_DONE: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        if (start) begin
          state_d = START;
          data_d  = tx_byte;
          txd_d   = 1'b0;
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d = DATA;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            data_d = {1'b0, data_q[7:1]};
            txd_d  = data_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d = UART_DONE;
          fin_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      fin_q   <= fin_d;
    end
  end

  assign txd = txd_q;
  assign fin = fin_q;

endmodule

// File: rtl/mio_periph.sv
// rtl/mio_periph.sv - iob write-request decode, GPIO register, UART launch and done generation
module mio_periph
  import mio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int GPIO_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iob__mio_val,
  input  logic              iob__mio_port,
  input  logic [31:0]       iob__mio_wdata,
  output logic              mio__iob_done,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_txd
);

  mio_state_e        state_q, state_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              done_q, done_d;
  logic              ready, accept, uart_start, uart_fin;
  logic              unused_wdata;

  assign unused_wdata = ^iob__mio_wdata[31:8];

  // START here means "frame in flight"; the fin cycle is the done cycle and is already idle
  assign ready      = (state_q != START) || uart_fin;
  assign accept     = iob__mio_val && ready;
  assign uart_start = accept && (iob__mio_port == MIO_PORT_UART);

  always_comb begin
    state_d = state_q;
    gpio_d  = gpio_q;
    done_d  = 1'b0;
    if (accept) begin
      if (iob__mio_port == MIO_PORT_UART) begin
        state_d = START;
      end else begin
        state_d = GPIO_DONE;
        gpio_d  = iob__mio_wdata[GPIO_W-1:0];
        done_d  = 1'b1;
      end
    end else if ((state_q == GPIO_DONE) || uart_fin) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gpio_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gpio_q  <= gpio_d;
      done_q  <= done_d;
    end
  end

  mio_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (uart_start),
    .tx_byte(iob__mio_wdata[7:0]),
    .txd    (uart_txd),
    .fin    (uart_fin)
  );

  assign gpio_out      = gpio_q;
  assign mio__iob_done = done_q | uart_fin;

endmodule

// File: tb/tb_mio_periph.sv
// tb/tb_mio_periph.sv - directed and randomized checks of mio_periph against a frame-level model
module tb_mio_periph;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        val = 1'b0;
  logic        port = 1'b0;
  logic [31:0] wdata = '0;
  logic        done;
  logic [3:0]  gpio_out;
  logic        txd;

  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] gpio_model = '0;

  always #5 clk = ~clk;

  mio_periph #(
    .CLKS_PER_BIT(CPB),
    .GPIO_W      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iob__mio_val  (val),
    .iob__mio_port (port),
    .iob__mio_wdata(wdata),
    .mio__iob_done (done),
    .gpio_out      (gpio_out),
    .uart_txd      (txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller has just raised val for a UART write at a falling edge (cycle N).
  // Frame bit b occupies cycles N+1+b*CPB .. N+(b+1)*CPB; done expected once at N+1+10*CPB.
  task automatic uart_frame(input logic [7:0] b, input bit busy);
    int   dones;
    int   done_at;
    int   bi;
    logic exp_bit;
    dones   = 0;
    done_at = -1;
    for (int k = 1; k <= 10 * CPB + 3; k++) begin
      @(negedge clk);
      if (k == 1) val = 1'b0;
      if (busy && k == 2 * CPB) begin
        val   = 1'b1;
        port  = 1'b0;
        wdata = 32'h0000_000F;
      end
      if (busy && k == 2 * CPB + 1) val = 1'b0;
      if (done) begin
        dones++;
        done_at = k;
      end
      if ((k - 1) % CPB == CPB / 2) begin
        bi = (k - 1) / CPB;
        if (bi < 10) begin
          exp_bit = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
          check($sformatf("txd_bit%0d_byte%02h", bi, b), {31'b0, txd}, {31'b0, exp_bit});
        end
      end
    end
    check("uart_done_count", dones, 1);
    check("uart_done_cycle", done_at, 10 * CPB + 1);
    check("uart_gpio_hold", {28'b0, gpio_out}, {28'b0, gpio_model});
    check("uart_idle_txd", {31'b0, txd}, 32'd1);
  endtask

  task automatic start_uart(input logic [7:0] b);
    @(negedge clk);
    val   = 1'b1;
    port  = 1'b1;
    wdata = {24'($urandom), b};
  endtask

  task automatic gpio_write(input logic [31:0] d, input bit chain, input logic [7:0] ub);
    @(negedge clk);
    val   = 1'b1;
    port  = 1'b0;
    wdata = d;
    @(negedge clk);
    val        = 1'b0;
    gpio_model = d[3:0];
    check("gpio_value", {28'b0, gpio_out}, {28'b0, gpio_model});
    check("gpio_done", {31'b0, done}, 32'd1);
    if (chain) begin
      val   = 1'b1;
      port  = 1'b1;
      wdata = {24'($urandom), ub};
      uart_frame(ub, 1'b0);
    end else begin
      @(negedge clk);
      check("gpio_done_clear", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int         stray;
    logic [7:0] rb;

    // power-on reset asserted between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_gpio", {28'b0, gpio_out}, 32'd0);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    gpio_write(32'hFFFF_FFF5, 1'b0, 8'h00);

    start_uart(8'hA5);
    uart_frame(8'hA5, 1'b1);

    gpio_write(32'h0000_0003, 1'b1, 8'h00);

    for (int i = 0; i < 4; i++) begin
      gpio_write($urandom, 1'b0, 8'h00);
      rb = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        gpio_write($urandom, 1'b1, rb);
      end else begin
        start_uart(rb);
        uart_frame(rb, 1'($urandom_range(0, 1)));
      end
    end

    // abort a frame during data bit index 3 (fifth frame bit)
    gpio_write(32'h0000_0009, 1'b0, 8'h00);
    start_uart(8'h00);
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      if (k == 1) val = 1'b0;
    end
    check("abort_mid_txd_low", {31'b0, txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    gpio_model = '0;
    check("abort_txd", {31'b0, txd}, 32'd1);
    check("abort_gpio", {28'b0, gpio_out}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12 * CPB; k++) begin
      @(negedge clk);
      if (done || !txd) stray++;
    end
    check("abort_no_done_or_txd", stray, 0);

    start_uart(8'h55);
    uart_frame(8'h55, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
